// File: rtl/axi4l_cmd_master_if.sv
`default_nettype none
// ============================================================================
// Module      : axi4l_cmd_master_if
// Description : Bundles the command port, response port and the five
//               AXI4-Lite master channels of axi4l_cmd_master.
//               master modport = block view, slave modport = environment view.
// Revision    : 1.0  initial release
// ============================================================================
interface axi4l_cmd_master_if;
  // command port
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  // response port
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;
  // AXI4-Lite write address / data / response
  logic [31:0] m_axi4l_awaddr;
  logic [2:0]  m_axi4l_awprot;
  logic        m_axi4l_awvalid;
  logic        m_axi4l_awready;
  logic [31:0] m_axi4l_wdata;
  logic [3:0]  m_axi4l_wstrb;
  logic        m_axi4l_wvalid;
  logic        m_axi4l_wready;
  logic [1:0]  m_axi4l_bresp;
  logic        m_axi4l_bvalid;
  logic        m_axi4l_bready;
  // AXI4-Lite read address / data
  logic [31:0] m_axi4l_araddr;
  logic [2:0]  m_axi4l_arprot;
  logic        m_axi4l_arvalid;
  logic        m_axi4l_arready;
  logic [31:0] m_axi4l_rdata;
  logic [1:0]  m_axi4l_rresp;
  logic        m_axi4l_rvalid;
  logic        m_axi4l_rready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
    input  m_axi4l_awready, m_axi4l_wready, m_axi4l_bresp, m_axi4l_bvalid,
    input  m_axi4l_arready, m_axi4l_rdata, m_axi4l_rresp, m_axi4l_rvalid,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
    output m_axi4l_awaddr, m_axi4l_awprot, m_axi4l_awvalid,
    output m_axi4l_wdata, m_axi4l_wstrb, m_axi4l_wvalid, m_axi4l_bready,
    output m_axi4l_araddr, m_axi4l_arprot, m_axi4l_arvalid, m_axi4l_rready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
    output m_axi4l_awready, m_axi4l_wready, m_axi4l_bresp, m_axi4l_bvalid,
    output m_axi4l_arready, m_axi4l_rdata, m_axi4l_rresp, m_axi4l_rvalid,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
    input  m_axi4l_awaddr, m_axi4l_awprot, m_axi4l_awvalid,
    input  m_axi4l_wdata, m_axi4l_wstrb, m_axi4l_wvalid, m_axi4l_bready,
    input  m_axi4l_araddr, m_axi4l_arprot, m_axi4l_arvalid, m_axi4l_rready
  );
endinterface
`default_nettype wire

// File: rtl/axi4l_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : axi4l_cmd_master
// Description : Converts single read/write commands from a valid/ready
//               command port into AXI4-Lite transactions, one outstanding at
//               a time, and returns BRESP/RRESP (+ read data) on a
//               valid/ready response port. All outputs are registered.
//               Optional macro AXI4L_CMD_MASTER_TIMEOUT_EN adds a watchdog
//               that aborts a stuck transaction after TIMEOUT_CYCLES cycles.
// Revision    : 1.0  initial release
// ============================================================================
module axi4l_cmd_master #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  wire logic           m_axi4l_aclk,
  input  wire logic           m_axi4l_aresetn,
  axi4l_cmd_master_if.master  bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_RESP    = 3'd5
  } state_t;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("axi4l_cmd_master: TIMEOUT_CYCLES must be at least 2");
  end

  state_t      state;
  logic        cmd_ready_q;
  logic        awvalid_q;
  logic        wvalid_q;
  logic        arvalid_q;
  logic        bready_q;
  logic        rready_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic [1:0]  rsp_resp_q;

  // A write channel counts as finished once its valid has dropped or is
  // being accepted this cycle; AW and W complete independently.
  logic aw_done;
  logic w_done;
  assign aw_done = !awvalid_q || bus.m_axi4l_awready;
  assign w_done  = !wvalid_q  || bus.m_axi4l_wready;

`ifdef AXI4L_CMD_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_active;
  logic             timeout_hit;
  logic             timeout_q;

  assign tmo_active  = (state == ST_WR_ADDR) || (state == ST_WR_RESP) ||
                       (state == ST_RD_ADDR) || (state == ST_RD_DATA);
  // Last waiting cycle: the abort takes effect on this edge.
  assign timeout_hit = tmo_active && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: held at zero while idle, counts every cycle spent waiting on the bus.
  always_ff @(posedge m_axi4l_aclk or negedge m_axi4l_aresetn) begin
    if (!m_axi4l_aresetn) begin
      tmo_cnt <= '0;
    end else if (state == ST_IDLE) begin
      tmo_cnt <= '0;
    end else if (tmo_active && !timeout_hit) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign bus.rsp_timeout = timeout_q;
`else
  assign bus.rsp_timeout = 1'b0;
`endif

  // Transaction FSM; every bus-facing output is a register updated here.
  always_ff @(posedge m_axi4l_aclk or negedge m_axi4l_aresetn) begin
    if (!m_axi4l_aresetn) begin
      state       <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
`ifdef AXI4L_CMD_MASTER_TIMEOUT_EN
      timeout_q   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_ready_q && bus.cmd_valid) begin
            cmd_ready_q <= 1'b0;
            addr_q      <= bus.cmd_addr;
            wdata_q     <= bus.cmd_wdata;
            wstrb_q     <= bus.cmd_wstrb;
            if (bus.cmd_write) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state     <= ST_WR_ADDR;
            end else begin
              arvalid_q <= 1'b1;
              state     <= ST_RD_ADDR;
            end
          end else begin
            // Also raises cmd_ready on the first clock after reset release.
            cmd_ready_q <= 1'b1;
          end
        end

        ST_WR_ADDR: begin
          if (bus.m_axi4l_awready) awvalid_q <= 1'b0;
          if (bus.m_axi4l_wready)  wvalid_q  <= 1'b0;
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            state    <= ST_WR_RESP;
          end
        end

        ST_WR_RESP: begin
          if (bus.m_axi4l_bvalid) begin
            bready_q    <= 1'b0;
            rsp_resp_q  <= bus.m_axi4l_bresp;
            rsp_rdata_q <= '0;
            rsp_valid_q <= 1'b1;
            state       <= ST_RESP;
          end
        end

        ST_RD_ADDR: begin
          if (bus.m_axi4l_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= ST_RD_DATA;
          end
        end

        ST_RD_DATA: begin
          if (bus.m_axi4l_rvalid) begin
            rready_q    <= 1'b0;
            rsp_rdata_q <= bus.m_axi4l_rdata;
            rsp_resp_q  <= bus.m_axi4l_rresp;
            rsp_valid_q <= 1'b1;
            state       <= ST_RESP;
          end
        end

        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
`ifdef AXI4L_CMD_MASTER_TIMEOUT_EN
            timeout_q   <= 1'b0;
`endif
            state       <= ST_IDLE;
          end
        end

        default: begin
          state       <= ST_IDLE;
          awvalid_q   <= 1'b0;
          wvalid_q    <= 1'b0;
          arvalid_q   <= 1'b0;
          bready_q    <= 1'b0;
          rready_q    <= 1'b0;
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b0;
        end
      endcase

`ifdef AXI4L_CMD_MASTER_TIMEOUT_EN
      // Abort overrides whatever the wait state decided on this edge.
      if (timeout_hit) begin
        awvalid_q   <= 1'b0;
        wvalid_q    <= 1'b0;
        arvalid_q   <= 1'b0;
        bready_q    <= 1'b0;
        rready_q    <= 1'b0;
        timeout_q   <= 1'b1;
        rsp_resp_q  <= 2'b10;
        rsp_rdata_q <= '0;
        rsp_valid_q <= 1'b1;
        state       <= ST_RESP;
      end
`endif
    end
  end

  assign bus.cmd_ready       = cmd_ready_q;
  assign bus.m_axi4l_awaddr  = addr_q;
  assign bus.m_axi4l_awprot  = 3'b000;
  assign bus.m_axi4l_awvalid = awvalid_q;
  assign bus.m_axi4l_wdata   = wdata_q;
  assign bus.m_axi4l_wstrb   = wstrb_q;
  assign bus.m_axi4l_wvalid  = wvalid_q;
  assign bus.m_axi4l_bready  = bready_q;
  assign bus.m_axi4l_araddr  = addr_q;
  assign bus.m_axi4l_arprot  = 3'b000;
  assign bus.m_axi4l_arvalid = arvalid_q;
  assign bus.m_axi4l_rready  = rready_q;
  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_rdata       = rsp_rdata_q;
  assign bus.rsp_resp        = rsp_resp_q;

endmodule
`default_nettype wire

// File: tb/tb_axi4l_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi4l_cmd_master
// Description : Self-checking bench for axi4l_cmd_master. A cycle-stepped
//               AXI4-Lite slave with programmable waits and a backing memory
//               plays the peripheral; a separate reference memory predicts
//               read data. Build with +define+AXI4L_CMD_MASTER_TIMEOUT_EN to
//               exercise the watchdog.
// Revision    : 1.0  initial release
// ============================================================================
module tb_axi4l_cmd_master;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  axi4l_cmd_master_if bus();

  axi4l_cmd_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .m_axi4l_aclk    (clk),
    .m_axi4l_aresetn (rst_n),
    .bus             (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] slv_mem [logic [31:0]];

  // observations gathered by run_txn
  int          o_aw_cyc, o_w_cyc, o_ar_cyc, o_rsp_k, o_rsp_cyc;
  bit          o_hung, o_w_unstable, o_rdy_bad, o_cmd_busy, o_rsp_unstable;
  bit          o_after_ok, o_bad_prot, o_busy_at_rsp;
  logic [31:0] o_awaddr, o_wdata, o_araddr, o_rdata;
  logic [3:0]  o_wstrb;
  logic [1:0]  o_resp;
  logic        o_tmo;

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  function automatic void ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] cur;
    cur = ref_read(a);
    for (int b = 0; b < 4; b++) if (s[b]) cur[8*b +: 8] = d[8*b +: 8];
    ref_mem[a] = cur;
  endfunction

  task automatic idle_bus();
    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = 0; bus.cmd_wdata = 0; bus.cmd_wstrb = 0;
    bus.rsp_ready = 0;
    bus.m_axi4l_awready = 0; bus.m_axi4l_wready = 0; bus.m_axi4l_bvalid = 0; bus.m_axi4l_bresp = 0;
    bus.m_axi4l_arready = 0; bus.m_axi4l_rvalid = 0; bus.m_axi4l_rdata = 0; bus.m_axi4l_rresp = 0;
  endtask

  // Issue one command and play the slave. a_dly/w_dly: cycles of valid before
  // ready; x_dly (>=1): cycles after address/data completion until B/R valid.
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input int a_dly, input int w_dly, input int x_dly,
                         input logic [1:0] xresp, input bit force_rd, input logic [31:0] forced,
                         input int hold, input int max_k);
    int k, aw_seen, w_seen, ar_seen, x_wait, held;
    bit aw_done, w_done, ar_done, x_done, rsp_hs, fin;
    logic [31:0] w_first, mask, cur;
    k = 0; aw_seen = 0; w_seen = 0; ar_seen = 0; x_wait = 0; held = 0;
    aw_done = 0; w_done = 0; ar_done = 0; x_done = 0; rsp_hs = 0; fin = 0; w_first = 0;
    o_aw_cyc = 0; o_w_cyc = 0; o_ar_cyc = 0; o_rsp_k = 0; o_rsp_cyc = 0;
    o_hung = 0; o_w_unstable = 0; o_rdy_bad = 0; o_cmd_busy = 0; o_rsp_unstable = 0;
    o_after_ok = 0; o_bad_prot = 0; o_busy_at_rsp = 0;
    o_awaddr = 0; o_wdata = 0; o_wstrb = 0; o_araddr = 0; o_rdata = 0; o_resp = 0; o_tmo = 0;

    @(negedge clk);
    bus.cmd_valid = 1; bus.cmd_write = wr; bus.cmd_addr = addr; bus.cmd_wdata = wdata; bus.cmd_wstrb = strb;
    while (!bus.cmd_ready && k < max_k) begin @(negedge clk); k++; end
    if (!bus.cmd_ready) begin o_hung = 1; bus.cmd_valid = 0; return; end
    k = 0;
    while (!fin) begin
      @(negedge clk); k++;
      if (k == 1) begin
        // scramble the command bus: the block must work from its captured copy
        bus.cmd_valid = 0; bus.cmd_write = 1'($urandom);
        bus.cmd_addr = $urandom; bus.cmd_wdata = $urandom; bus.cmd_wstrb = 4'($urandom);
      end
      if (k > max_k) begin
        o_hung = 1; fin = 1;
      end else if (rsp_hs) begin
        o_after_ok = !bus.rsp_valid && bus.cmd_ready;
        bus.rsp_ready = 0; fin = 1;
      end else begin
        if (bus.cmd_ready) o_cmd_busy = 1;
        if (bus.m_axi4l_awprot !== 3'b000 || bus.m_axi4l_arprot !== 3'b000) o_bad_prot = 1;
        if (bus.m_axi4l_bready && (!wr || !(aw_done && w_done) || x_done)) o_rdy_bad = 1;
        if (bus.m_axi4l_rready && (wr || !ar_done || x_done)) o_rdy_bad = 1;
        if (!wr && (bus.m_axi4l_awvalid || bus.m_axi4l_wvalid)) o_rdy_bad = 1;
        if (wr && bus.m_axi4l_arvalid) o_rdy_bad = 1;
        // response channels
        bus.m_axi4l_bvalid = 0; bus.m_axi4l_rvalid = 0;
        if (wr && aw_done && w_done && !x_done) begin
          x_wait++;
          if (x_wait >= x_dly) begin
            bus.m_axi4l_bvalid = 1; bus.m_axi4l_bresp = xresp;
            if (bus.m_axi4l_bready) begin
              x_done = 1;
              mask = {{8{o_wstrb[3]}}, {8{o_wstrb[2]}}, {8{o_wstrb[1]}}, {8{o_wstrb[0]}}};
              cur = slv_mem.exists(o_awaddr) ? slv_mem[o_awaddr] : 32'h0;
              slv_mem[o_awaddr] = (cur & ~mask) | (o_wdata & mask);
            end
          end
        end
        if (!wr && ar_done && !x_done) begin
          x_wait++;
          if (x_wait >= x_dly) begin
            bus.m_axi4l_rvalid = 1; bus.m_axi4l_rresp = xresp;
            bus.m_axi4l_rdata = force_rd ? forced : (slv_mem.exists(o_araddr) ? slv_mem[o_araddr] : 32'h0);
            if (bus.m_axi4l_rready) x_done = 1;
          end
        end
        // address / data channels
        bus.m_axi4l_awready = 0; bus.m_axi4l_wready = 0; bus.m_axi4l_arready = 0;
        if (bus.m_axi4l_awvalid) begin
          o_aw_cyc++;
          if (aw_seen >= a_dly) begin bus.m_axi4l_awready = 1; aw_done = 1; o_awaddr = bus.m_axi4l_awaddr; end
          aw_seen++;
        end
        if (bus.m_axi4l_wvalid) begin
          o_w_cyc++;
          if (w_seen == 0) w_first = bus.m_axi4l_wdata;
          else if (bus.m_axi4l_wdata !== w_first) o_w_unstable = 1;
          if (w_seen >= w_dly) begin
            bus.m_axi4l_wready = 1; w_done = 1; o_wdata = bus.m_axi4l_wdata; o_wstrb = bus.m_axi4l_wstrb;
          end
          w_seen++;
        end
        if (bus.m_axi4l_arvalid) begin
          o_ar_cyc++;
          if (ar_seen >= a_dly) begin bus.m_axi4l_arready = 1; ar_done = 1; o_araddr = bus.m_axi4l_araddr; end
          ar_seen++;
        end
        // response port
        if (bus.rsp_valid) begin
          o_rsp_cyc++;
          if (o_rsp_k == 0) begin
            o_rsp_k = k; o_rdata = bus.rsp_rdata; o_resp = bus.rsp_resp; o_tmo = bus.rsp_timeout;
            o_busy_at_rsp = bus.m_axi4l_awvalid | bus.m_axi4l_wvalid | bus.m_axi4l_arvalid |
                            bus.m_axi4l_bready | bus.m_axi4l_rready;
          end else if (bus.rsp_rdata !== o_rdata || bus.rsp_resp !== o_resp || bus.rsp_timeout !== o_tmo) begin
            o_rsp_unstable = 1;
          end
          if (held >= hold) begin bus.rsp_ready = 1; rsp_hs = 1; end
          held++;
        end
      end
    end
    bus.m_axi4l_awready = 0; bus.m_axi4l_wready = 0; bus.m_axi4l_arready = 0;
    bus.m_axi4l_bvalid = 0; bus.m_axi4l_rvalid = 0; bus.rsp_ready = 0;
  endtask

  task automatic test_reset();
    idle_bus();
    rst_n = 0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.m_axi4l_awvalid, bus.m_axi4l_wvalid, bus.m_axi4l_arvalid, bus.m_axi4l_bready,
         bus.m_axi4l_rready, bus.rsp_valid, bus.rsp_timeout} !== 7'b0 || bus.rsp_rdata !== 32'h0 || bus.rsp_resp !== 2'b00) begin
      bad++; $display("FAIL reset_outputs: got valids/readies=%b rdata=%h resp=%b, want all zero",
        {bus.m_axi4l_awvalid, bus.m_axi4l_wvalid, bus.m_axi4l_arvalid, bus.m_axi4l_bready,
         bus.m_axi4l_rready, bus.rsp_valid, bus.rsp_timeout}, bus.rsp_rdata, bus.rsp_resp);
    end
    rst_n = 1;
    @(negedge clk);
    total++;
    if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready); end
  endtask

  task automatic test_zero_wait_write();
    run_txn(1, 32'h0000_0000, 32'hA5A5_1234, 4'hF, 0, 0, 1, 2'b00, 0, 0, 0, 40);
    ref_write(32'h0, 32'hA5A5_1234, 4'hF);
    total++;
    if (o_hung || o_rsp_k !== 3) begin bad++; $display("FAIL zw_write_latency: got %0d (hung=%0d) want 3", o_rsp_k, o_hung); end
    total++;
    if (o_aw_cyc !== 1 || o_w_cyc !== 1) begin bad++; $display("FAIL zw_write_valid_cycles: got aw=%0d w=%0d want 1/1", o_aw_cyc, o_w_cyc); end
    total++;
    if (o_resp !== 2'b00 || o_rdata !== 32'h0) begin bad++; $display("FAIL zw_write_rsp: got resp=%b rdata=%h want 00/0", o_resp, o_rdata); end
    total++;
    if ({o_awaddr, o_wdata, o_wstrb} !== {32'h0, 32'hA5A5_1234, 4'hF}) begin
      bad++; $display("FAIL zw_write_bus: got addr=%h data=%h strb=%h want 0/a5a51234/f", o_awaddr, o_wdata, o_wstrb);
    end
    total++;
    if (!o_after_ok || o_bad_prot || o_rdy_bad) begin
      bad++; $display("FAIL zw_write_protocol: got after_ok=%0d prot=%0d rdy=%0d want 1/0/0", o_after_ok, o_bad_prot, o_rdy_bad);
    end
    // back-to-back zero-wait read of the same word
    run_txn(0, 32'h0000_0000, 32'h0, 4'h0, 0, 0, 1, 2'b00, 0, 0, 0, 40);
    total++;
    if (o_rsp_k !== 3 || o_rdata !== ref_read(32'h0)) begin
      bad++; $display("FAIL zw_readback: got k=%0d rdata=%h want 3/%h", o_rsp_k, o_rdata, ref_read(32'h0));
    end
  endtask

  task automatic test_slow_wready();
    run_txn(1, 32'h0000_0008, 32'h1357_9BDF, 4'hF, 0, 3, 1, 2'b00, 0, 0, 0, 40);
    ref_write(32'h8, 32'h1357_9BDF, 4'hF);
    total++;
    if (o_aw_cyc !== 1 || o_w_cyc !== 4) begin bad++; $display("FAIL slow_w_cycles: got aw=%0d w=%0d want 1/4", o_aw_cyc, o_w_cyc); end
    total++;
    if (o_w_unstable || o_wdata !== 32'h1357_9BDF) begin bad++; $display("FAIL slow_w_wdata: got %h unstable=%0d want 13579bdf", o_wdata, o_w_unstable); end
    total++;
    if (o_rdy_bad) begin bad++; $display("FAIL slow_w_bready_early: got 1 want 0"); end
    total++;
    if (o_rsp_k !== 6) begin bad++; $display("FAIL slow_w_latency: got %0d want 6", o_rsp_k); end
  endtask

  task automatic test_slow_read();
    run_txn(0, 32'h0000_0010, 32'h0, 4'h0, 0, 0, 5, 2'b00, 1, 32'hDEAD_BEEF, 0, 40);
    total++;
    if (o_rdata !== 32'hDEAD_BEEF || o_resp !== 2'b00) begin bad++; $display("FAIL slow_read_rsp: got %h/%b want deadbeef/00", o_rdata, o_resp); end
    total++;
    if (o_cmd_busy) begin bad++; $display("FAIL slow_read_cmd_ready: got 1 during transaction want 0"); end
    total++;
    if (o_rsp_k !== 7 || o_ar_cyc !== 1 || o_araddr !== 32'h10) begin
      bad++; $display("FAIL slow_read_timing: got k=%0d ar=%0d addr=%h want 7/1/10", o_rsp_k, o_ar_cyc, o_araddr);
    end
  endtask

  task automatic test_bresp_hold();
    run_txn(1, 32'h0000_0014, 32'h0BAD_F00D, 4'h3, 0, 0, 1, 2'b10, 0, 0, 4, 40);
    ref_write(32'h14, 32'h0BAD_F00D, 4'h3);
    total++;
    if (o_resp !== 2'b10 || o_rsp_unstable) begin bad++; $display("FAIL hold_resp: got %b unstable=%0d want 10/0", o_resp, o_rsp_unstable); end
    total++;
    if (o_rsp_cyc !== 5) begin bad++; $display("FAIL hold_rsp_cycles: got %0d want 5", o_rsp_cyc); end
    total++;
    if (o_cmd_busy || !o_after_ok) begin bad++; $display("FAIL hold_cmd_ready: got busy=%0d after_ok=%0d want 0/1", o_cmd_busy, o_after_ok); end
  endtask

  task automatic test_reset_mid_read();
    int k;
    bit in_rd;
    @(negedge clk);
    bus.cmd_valid = 1; bus.cmd_write = 0; bus.cmd_addr = 32'h0000_0010;
    k = 0;
    while (!bus.cmd_ready && k < 20) begin @(negedge clk); k++; end
    @(negedge clk);
    bus.cmd_valid = 0;
    in_rd = 0; k = 0;
    while (!in_rd && k < 20) begin
      bus.m_axi4l_arready = bus.m_axi4l_arvalid;
      if (bus.m_axi4l_rready) in_rd = 1;
      else begin @(negedge clk); k++; end
    end
    bus.m_axi4l_arready = 0;
    total++;
    if (!in_rd) begin bad++; $display("FAIL rst_reach_rd_data: got rready never high want high"); end
    rst_n = 0;
    #1;
    total++;
    if ({bus.m_axi4l_arvalid, bus.m_axi4l_rready, bus.rsp_valid, bus.cmd_ready} !== 4'b0) begin
      bad++; $display("FAIL rst_async_clear: got arvalid/rready/rsp_valid/cmd_ready=%b want 0000",
        {bus.m_axi4l_arvalid, bus.m_axi4l_rready, bus.rsp_valid, bus.cmd_ready});
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    total++;
    if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      bad++; $display("FAIL rst_release: got cmd_ready=%b rsp_valid=%b want 1/0", bus.cmd_ready, bus.rsp_valid);
    end
    run_txn(1, 32'h0000_0018, 32'hCAFE_0001, 4'hF, 0, 0, 1, 2'b00, 0, 0, 0, 40);
    ref_write(32'h18, 32'hCAFE_0001, 4'hF);
    total++;
    if (o_rsp_k !== 3 || o_resp !== 2'b00 || o_wdata !== 32'hCAFE_0001 || !o_after_ok) begin
      bad++; $display("FAIL rst_fresh_write: got k=%0d resp=%b wdata=%h after_ok=%0d want 3/00/cafe0001/1", o_rsp_k, o_resp, o_wdata, o_after_ok);
    end
  endtask

  task automatic test_timeout();
`ifdef AXI4L_CMD_MASTER_TIMEOUT_EN
    run_txn(1, 32'h0000_001C, 32'h7777_7777, 4'hF, 1000, 0, 1, 2'b00, 0, 0, 0, 100);
    total++;
    if (o_hung || o_rsp_k !== TMO + 1) begin bad++; $display("FAIL tmo_latency: got %0d (hung=%0d) want %0d", o_rsp_k, o_hung, TMO + 1); end
    total++;
    if (o_tmo !== 1'b1 || o_resp !== 2'b10 || o_rdata !== 32'h0) begin
      bad++; $display("FAIL tmo_rsp: got tmo=%b resp=%b rdata=%h want 1/10/0", o_tmo, o_resp, o_rdata);
    end
    total++;
    if (o_busy_at_rsp || o_aw_cyc !== TMO) begin
      bad++; $display("FAIL tmo_awvalid: got busy=%0d aw_cycles=%0d want 0/%0d", o_busy_at_rsp, o_aw_cyc, TMO);
    end
`else
    run_txn(1, 32'h0000_001C, 32'h7777_7777, 4'hF, 1000, 0, 1, 2'b00, 0, 0, 0, 100);
    total++;
    if (!o_hung || o_rsp_k !== 0) begin bad++; $display("FAIL no_tmo_wait: got hung=%0d rsp_k=%0d want 1/0", o_hung, o_rsp_k); end
    idle_bus();
    @(negedge clk); rst_n = 0;
    repeat (2) @(negedge clk); rst_n = 1;
    @(negedge clk);
    total++;
    if (bus.cmd_ready !== 1'b1 || bus.rsp_timeout !== 1'b0) begin
      bad++; $display("FAIL no_tmo_recover: got cmd_ready=%b timeout=%b want 1/0", bus.cmd_ready, bus.rsp_timeout);
    end
`endif
  endtask

  task automatic test_random();
    bit wr;
    logic [31:0] addr, data, exp_rd;
    logic [3:0] strb;
    logic [1:0] resp;
    int ad, wd, xd, hold, exp_k;
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom_range(0, 1));
      addr = {27'h0, 3'($urandom_range(0, 7)), 2'b00};
      data = $urandom; strb = 4'($urandom); resp = 2'($urandom);
      ad = $urandom_range(0, 3); wd = $urandom_range(0, 3); xd = $urandom_range(1, 3); hold = $urandom_range(0, 2);
      exp_rd = wr ? 32'h0 : ref_read(addr);
      exp_k  = wr ? (((ad > wd) ? ad : wd) + xd + 2) : (ad + xd + 2);
      run_txn(wr, addr, data, strb, ad, wd, xd, resp, 0, 0, hold, 60);
      total++;
      if (o_hung || o_rsp_k !== exp_k) begin bad++; $display("FAIL rnd_latency[%0d]: got %0d (hung=%0d) want %0d", i, o_rsp_k, o_hung, exp_k); end
      total++;
      if (o_rdata !== exp_rd || o_resp !== resp || o_tmo !== 1'b0) begin
        bad++; $display("FAIL rnd_rsp[%0d]: got rdata=%h resp=%b tmo=%b want %h/%b/0", i, o_rdata, o_resp, o_tmo, exp_rd, resp);
      end
      if (wr) begin
        ref_write(addr, data, strb);
        total++;
        if ({o_awaddr, o_wdata, o_wstrb} !== {addr, data, strb} || o_aw_cyc !== ad + 1 || o_w_cyc !== wd + 1) begin
          bad++; $display("FAIL rnd_write_bus[%0d]: got %h/%h/%h cyc=%0d/%0d want %h/%h/%h cyc=%0d/%0d",
            i, o_awaddr, o_wdata, o_wstrb, o_aw_cyc, o_w_cyc, addr, data, strb, ad + 1, wd + 1);
        end
      end else begin
        total++;
        if (o_araddr !== addr || o_ar_cyc !== ad + 1) begin
          bad++; $display("FAIL rnd_read_bus[%0d]: got %h cyc=%0d want %h cyc=%0d", i, o_araddr, o_ar_cyc, addr, ad + 1);
        end
      end
      total++;
      if (o_cmd_busy || o_rdy_bad || o_w_unstable || o_rsp_unstable || o_bad_prot || !o_after_ok || o_rsp_cyc !== hold + 1) begin
        bad++; $display("FAIL rnd_protocol[%0d]: got busy=%0d rdy=%0d wun=%0d run=%0d prot=%0d after=%0d rspcyc=%0d want 0/0/0/0/0/1/%0d",
          i, o_cmd_busy, o_rdy_bad, o_w_unstable, o_rsp_unstable, o_bad_prot, o_after_ok, o_rsp_cyc, hold + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait_write();
    test_slow_wready();
    test_slow_read();
    test_bresp_hold();
    test_reset_mid_read();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
